serial_mult_n: RTL and testbench

- Bit-serial W×W multiplier. Operands A and B arrive LSB-first on single-bit inputs; the 2W-bit product leaves LSB-first on a single-bit output.
- Generalises the team's fixed 4-bit serial multiplier:
  - parametrised operand width;
  - run-time signed/unsigned mode;
  - sequential shift-add core;
  - explicit BUSY/OV/DONE handshake and an abort input.
- Sits between serial link front-ends and downstream serial consumers.

---
 rtl/serial_mult_pkg.sv | 26 ++
 rtl/serial_mult_n_step.sv | 21 ++
 rtl/serial_mult_n.sv | 158 +++++++++++++++
 tb/tb_serial_mult_n.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_pkg.sv
// rtl/serial_mult_pkg.sv - shared state encoding and sizing helpers for the serial multiplier
package serial_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        OUT
    } state_e;

    // Default operand width; the product width PW is always 2*W in every user.
    localparam int DEFAULT_W = 8;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_mult_n_step.sv
// rtl/serial_mult_n_step.sv - one combinational shift-add/subtract step of the multiplier core
module mult_step
    import serial_mult_pkg::*;
#(
    parameter int PW = 2 * DEFAULT_W
) (
    input  logic [PW-1:0] acc_i,
    input  logic [PW-1:0] mcand_i,
    input  logic          bit_i,
    input  logic          sub_i,
    output logic [PW-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        if (bit_i) begin
            acc_o = sub_i ? (acc_i - mcand_i) : (acc_i + mcand_i);
        end
    end

endmodule

// File: rtl/serial_mult_n.sv
// rtl/serial_mult_n.sv - bit-serial WxW multiplier, LSB-first operands in, 2W-bit product out
module serial_mult_n
    import serial_mult_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic IE,
    input  logic SGN,
    input  logic A,
    input  logic B,
    input  logic ABORT,
    output logic O,
    output logic OV,
    output logic BUSY,
    output logic DONE
);

    localparam int PW = 2 * W;
    localparam int CW = clog2(PW);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic            o_q, o_d;
    logic            ov_q, ov_d;
    logic            done_q, done_d;

    logic [W-1:0]    a_ins;
    logic [W-1:0]    b_ins;
    logic [PW-1:0]   acc_step;
    logic            step_sub;

    // Operand bits are OR-ed into place by position so no captured bit is ever shifted out.
    assign a_ins    = a_q | (W'(A) << (cnt_q + 1'b1));
    assign b_ins    = b_q | (W'(B) << (cnt_q + 1'b1));
    assign step_sub = sgn_q & (cnt_q == CW'(W - 1));

    mult_step #(.PW(PW)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .bit_i   (b_q[0]),
        .sub_i   (step_sub),
        .acc_o   (acc_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        o_d     = 1'b0;
        ov_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (IE && !ABORT) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    a_d     = W'(A);
                    b_d     = W'(B);
                    sgn_d   = SGN;
                    acc_d   = '0;
                end
            end
            LOAD: begin
                a_d = a_ins;
                b_d = b_ins;
                if (cnt_q == CW'(W - 2)) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    mcand_d = {{W{sgn_q & A}}, a_ins};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CALC: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                // The counter holds on the last bit; done_q marks the trailing return to IDLE.
                if (done_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    o_d   = acc_q[0];
                    ov_d  = 1'b1;
                    acc_d = acc_q >> 1;
                    if (cnt_q == CW'(PW - 1)) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ABORT && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            o_d     = 1'b0;
            ov_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            o_q     <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            o_q     <= o_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    assign O    = o_q;
    assign OV   = ov_q;
    assign DONE = done_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_serial_mult_n.sv
// tb/tb_serial_mult_n.sv - directed self-checking bench for serial_mult_n at W=4 and W=8
module tb_serial_mult_n;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    bit   sel = 1'b0;
    logic ie_s = 1'b0, a_s = 1'b0, b_s = 1'b0, sg_s = 1'b0, ab_s = 1'b0;

    logic ie4, ab4, o4, ov4, busy4, done4;
    logic ie8, ab8, o8, ov8, busy8, done8;
    logic o_s, ov_s, busy_s, done_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    assign ie4    = sel ? 1'b0 : ie_s;
    assign ab4    = sel ? 1'b0 : ab_s;
    assign ie8    = sel ? ie_s : 1'b0;
    assign ab8    = sel ? ab_s : 1'b0;
    assign o_s    = sel ? o8 : o4;
    assign ov_s   = sel ? ov8 : ov4;
    assign busy_s = sel ? busy8 : busy4;
    assign done_s = sel ? done8 : done4;

    serial_mult_n #(.W(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .IE(ie4), .SGN(sg_s), .A(a_s), .B(b_s), .ABORT(ab4),
        .O(o4), .OV(ov4), .BUSY(busy4), .DONE(done4)
    );

    serial_mult_n #(.W(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .IE(ie8), .SGN(sg_s), .A(a_s), .B(b_s), .ABORT(ab8),
        .O(o8), .OV(ov8), .BUSY(busy8), .DONE(done8)
    );

    // Drives one operation from the next negedge and collects the serial product.
    task automatic do_op(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv,
                         output logic [63:0] p, output int ovc, output int dnc,
                         output logic dn_ok, output logic end_idle);
        p = '0; ovc = 0; dnc = 0; dn_ok = 1'b0; end_idle = 1'b0;
        for (int i = 0; i < w; i++) begin
            @(negedge CLK);
            ie_s = (i == 0); a_s = av[i]; b_s = bv[i]; sg_s = s;
        end
        @(posedge CLK);
        @(negedge CLK);
        ie_s = 1'b0; a_s = 1'b0; b_s = 1'b0;
        for (int e = w; e <= 4 * w; e++) begin
            @(posedge CLK); #1;
            if (ov_s) ovc++;
            if (done_s) begin
                dnc++;
                if (e == 4 * w - 1) dn_ok = 1'b1;
            end
            if (e >= 2 * w && e < 4 * w) p[e - 2 * w] = o_s;
            if (e == 4 * w) end_idle = !busy_s && !ov_s && !o_s && !done_s;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; ie_s = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if ({o4, ov4, busy4, done4} !== 4'b0000) begin n_bad++; $display("FAIL reset_w4: got %b expected 0000", {o4, ov4, busy4, done4}); end
        n_cmp++; if ({o8, ov8, busy8, done8} !== 4'b0000) begin n_bad++; $display("FAIL reset_w8: got %b expected 0000", {o8, ov8, busy8, done8}); end
        @(negedge CLK);
        RST = 1'b0; ie_s = 1'b0;
    endtask

    task automatic test_unsigned_max();
        logic [63:0] p; int ovc, dnc; logic dok, eok;
        sel = 1'b0;
        do_op(4, 1'b0, 15, 15, p, ovc, dnc, dok, eok);
        n_cmp++; if (p !== 64'hE1) begin n_bad++; $display("FAIL u15x15_product: got %h expected e1", p); end
        n_cmp++; if (ovc !== 8) begin n_bad++; $display("FAIL u15x15_ov_count: got %0d expected 8", ovc); end
        n_cmp++; if (dnc !== 1) begin n_bad++; $display("FAIL u15x15_done_count: got %0d expected 1", dnc); end
        n_cmp++; if (dok !== 1'b1) begin n_bad++; $display("FAIL u15x15_done_position: got %b expected 1", dok); end
        n_cmp++; if (eok !== 1'b1) begin n_bad++; $display("FAIL u15x15_end_idle: got %b expected 1", eok); end
    endtask

    task automatic test_signed_mode();
        logic [63:0] p; int ovc, dnc; logic dok, eok;
        sel = 1'b0;
        do_op(4, 1'b1, 4'b1101, 4'b0101, p, ovc, dnc, dok, eok);
        n_cmp++; if (p !== 64'hF1) begin n_bad++; $display("FAIL s_m3x5: got %h expected f1", p); end
        do_op(4, 1'b0, 4'b1101, 4'b0101, p, ovc, dnc, dok, eok);
        n_cmp++; if (p !== 64'h41) begin n_bad++; $display("FAIL u_13x5: got %h expected 41", p); end
        n_cmp++; if (ovc !== 8) begin n_bad++; $display("FAIL u_13x5_ov_count: got %0d expected 8", ovc); end
    endtask

    task automatic test_signed_corners();
        logic [63:0] p; int ovc, dnc; logic dok, eok;
        sel = 1'b0;
        do_op(4, 1'b1, 4'b1000, 4'b1000, p, ovc, dnc, dok, eok);
        n_cmp++; if (p !== 64'h40) begin n_bad++; $display("FAIL s_m8xm8: got %h expected 40", p); end
        do_op(4, 1'b1, 4'b0111, 4'b1000, p, ovc, dnc, dok, eok);
        n_cmp++; if (p !== 64'hC8) begin n_bad++; $display("FAIL s_7xm8: got %h expected c8", p); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p1, p2; logic busy_ok, at33;
        sel = 1'b1; p1 = '0; p2 = '0; busy_ok = 1'b1; at33 = 1'b0;
        @(negedge CLK);
        ie_s = 1'b1; a_s = 1'b1; b_s = 1'b1; sg_s = 1'b0;
        for (int e = 0; e <= 65; e++) begin
            @(posedge CLK); #1;
            if (e >= 16 && e <= 31) p1[e - 16] = o_s;
            if (e >= 49 && e <= 64) p2[e - 49] = o_s;
            if (e == 32 || e == 65) begin
                if (busy_s) busy_ok = 1'b0;
            end else if (!busy_s) begin
                busy_ok = 1'b0;
            end
            if (e == 33) at33 = busy_s;
            if (e == 60) ie_s = 1'b0;
        end
        a_s = 1'b0; b_s = 1'b0;
        n_cmp++; if (p1 !== 16'hFE01) begin n_bad++; $display("FAIL w8_first_product: got %h expected fe01", p1); end
        n_cmp++; if (p2 !== 16'hFE01) begin n_bad++; $display("FAIL w8_second_product: got %h expected fe01", p2); end
        n_cmp++; if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL w8_busy_pattern: got %b expected 1", busy_ok); end
        n_cmp++; if (at33 !== 1'b1) begin n_bad++; $display("FAIL w8_restart_k33: got %b expected 1", at33); end
    endtask

    task automatic test_abort();
        logic [63:0] p; int ovc, dnc; logic dok, eok;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            ie_s = (i == 0); a_s = i[0]; b_s = 1'b1; sg_s = 1'b0;
        end
        @(negedge CLK);
        ie_s = 1'b0; a_s = 1'b0; b_s = 1'b0;
        @(negedge CLK);
        ab_s = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if ({busy_s, ov_s} !== 2'b00) begin n_bad++; $display("FAIL abort_calc: got %b expected 00", {busy_s, ov_s}); end
        @(negedge CLK);
        ab_s = 1'b0;
        @(posedge CLK); #1;
        n_cmp++; if ({busy_s, ov_s, o_s} !== 3'b000) begin n_bad++; $display("FAIL abort_quiet: got %b expected 000", {busy_s, ov_s, o_s}); end
        do_op(4, 1'b0, 3, 2, p, ovc, dnc, dok, eok);
        n_cmp++; if (p !== 64'h06) begin n_bad++; $display("FAIL abort_restart_3x2: got %h expected 06", p); end
        n_cmp++; if (ovc !== 8) begin n_bad++; $display("FAIL abort_restart_ov_count: got %0d expected 8", ovc); end
    endtask

    task automatic test_abort_idle();
        sel = 1'b0;
        @(negedge CLK);
        ie_s = 1'b1; ab_s = 1'b1; a_s = 1'b1; b_s = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL abort_wins_idle: got %b expected 0", busy_s); end
        @(negedge CLK);
        ie_s = 1'b0; ab_s = 1'b0; a_s = 1'b0; b_s = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] p; int ovc, dnc; logic dok, eok; logic ov9;
        sel = 1'b0; ov9 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            ie_s = (i == 0); a_s = 1'b1; b_s = i[0]; sg_s = 1'b0;
        end
        @(negedge CLK);
        ie_s = 1'b0; a_s = 1'b0; b_s = 1'b0;
        for (int e = 4; e <= 9; e++) begin
            @(posedge CLK); #1;
            if (e == 9) ov9 = ov_s;
        end
        n_cmp++; if (ov9 !== 1'b1) begin n_bad++; $display("FAIL rst_pre_out_phase: got %b expected 1", ov9); end
        @(negedge CLK);
        RST = 1'b1; ie_s = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if ({o_s, ov_s, done_s, busy_s} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_out: got %b expected 0000", {o_s, ov_s, done_s, busy_s}); end
        @(posedge CLK); #1;
        n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL rst_ie_no_start: got %b expected 0", busy_s); end
        @(negedge CLK);
        RST = 1'b0; ie_s = 1'b0;
        do_op(4, 1'b0, 9, 6, p, ovc, dnc, dok, eok);
        n_cmp++; if (p !== 64'h36) begin n_bad++; $display("FAIL rst_after_9x6: got %h expected 36", p); end
        n_cmp++; if (eok !== 1'b1) begin n_bad++; $display("FAIL rst_after_end_idle: got %b expected 1", eok); end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_mode();
        test_signed_corners();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
